// File: rtl/adc_capture_wr.sv
// -----------------------------------------------------------------------------
// adc_capture_wr
//
// Capture write controller. A capture request arms it. It then writes exactly
// DEPTH samples into the capture memory at addresses 0 .. DEPTH-1 and raises
// capture_done so the downstream packet read controller can start reading.
//
// Optional feature macro: ADC_CAP_SELF_TEST_EN
//   defined   -> self_test_mode replaces ADC data with a counting pattern
//                (the current address, zero-extended) and accepts a sample
//                on every CAPTURE cycle.
//   undefined -> self_test_mode is ignored. The port is kept for pin
//                compatibility.
//
// Ports
//   clk             in   capture clock, rising edge
//   rst             in   synchronous active-high reset
//   capture_start   in   one-cycle request: IDLE/DONE -> CAPTURE
//   capture_again   in   one-cycle request: DONE -> CAPTURE only
//   self_test_mode  in   level, selects counting pattern (macro permitting)
//   adc_data        in   [DATA_W-1:0] ADC sample
//   adc_valid       in   sample qualifier
//   mem_wr_en       out  one-cycle write strobe per accepted sample
//   mem_wr_addr     out  [ADDR_W-1:0] write address
//   mem_wr_data     out  [DATA_W-1:0] write data
//   capture_busy    out  high while capturing
//   capture_done    out  high from the final write until the next capture
//   wr_count        out  [ADDR_W:0] samples written in the current capture
//   state_dbg       out  [1:0] FSM state (0 IDLE, 1 CAPTURE, 2 DONE)
//
// Sample handshake: the ADC stream has no backpressure. A sample is accepted
// in any CAPTURE cycle where adc_valid is 1, or in every CAPTURE cycle while
// self-test is active. Samples seen outside CAPTURE are dropped. Each accepted
// sample produces exactly one mem_wr_en pulse on the following cycle, carrying
// that sample's address and data.
// -----------------------------------------------------------------------------
module adc_capture_wr #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic              self_test_mode,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              capture_busy,
  output logic              capture_done,
  output logic [ADDR_W:0]   wr_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // The sample counter is one bit wider than the address so that it can hold
  // DEPTH itself when DEPTH == 2**ADDR_W. It doubles as the write address.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic st_sel;
  logic accept;
  logic last_sample;
  logic restart;

`ifdef ADC_CAP_SELF_TEST_EN
  assign st_sel = self_test_mode;
`else
  logic unused_self_test_mode;
  assign unused_self_test_mode = self_test_mode;
  assign st_sel = 1'b0;
`endif

  assign accept      = (state_q == ST_CAPTURE) && (adc_valid || st_sel);
  assign last_sample = accept && (cnt_q == LAST_CNT);
  // capture_again is only honoured from DONE. Both requests together still
  // give one restart because they feed a single OR.
  assign restart     = ((state_q == ST_IDLE) && capture_start) ||
                       ((state_q == ST_DONE) && (capture_start || capture_again));

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Requests are not examined in CAPTURE, so a capture
  // always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (capture_start)                  state_d = ST_CAPTURE;
      ST_CAPTURE: if (last_sample)                    state_d = ST_DONE;
      ST_DONE:    if (capture_start || capture_again) state_d = ST_CAPTURE;
      default:                                        state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. Busy and done follow the next state so
  // that the final write cycle already shows done=1, busy=0.
  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = (state_d == ST_CAPTURE);
    done_d  = (state_d == ST_DONE);
    if (restart) begin
      cnt_d = '0;
    end else if (accept) begin
      wr_en_d = 1'b1;
      addr_d  = cnt_q[ADDR_W-1:0];
      data_d  = st_sel ? DATA_W'(cnt_q[ADDR_W-1:0]) : adc_data;
      cnt_d   = cnt_q + CNT_ONE;
    end
  end

  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = addr_q;
  assign mem_wr_data  = data_q;
  assign capture_busy = busy_q;
  assign capture_done = done_q;
  assign wr_count     = cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_adc_capture_wr.sv
// -----------------------------------------------------------------------------
// Testbench for adc_capture_wr (DEPTH reduced to 16).
// A behavioural model predicts every output cycle by cycle. A scoreboard
// queue holds hand-listed (address, data) writes, and literal checks pin
// latencies and write counts.
// -----------------------------------------------------------------------------
module tb_adc_capture_wr;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16;
`ifdef ADC_CAP_SELF_TEST_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              capture_start;
  logic              capture_again;
  logic              self_test_mode;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              capture_busy;
  logic              capture_done;
  logic [ADDR_W:0]   wr_count;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  adc_capture_wr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .capture_start (capture_start),
    .capture_again (capture_again),
    .self_test_mode(self_test_mode),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .capture_busy  (capture_busy),
    .capture_done  (capture_done),
    .wr_count      (wr_count),
    .state_dbg     (state_dbg)
  );

  int errors = 0;
  int checks = 0;
  int n_wr   = 0;
  bit chk_on = 1'b0;
  bit sb_on  = 1'b0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "capturing", "finished" and number of samples taken; each rising
  // edge yields the outputs that must be visible for the following cycle.
  bit                m_capturing, m_finished;
  int                m_taken;
  bit                e_en, e_busy, e_done;
  int                e_cnt;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;

  always @(posedge clk) begin
    bit st_on;
    if (rst) begin
      m_capturing = 0; m_finished = 0; m_taken = 0;
      e_en = 0; e_busy = 0; e_done = 0; e_cnt = 0; e_addr = '0; e_data = '0;
    end else begin
      e_en = 0;
      st_on = ST_EN && (self_test_mode === 1'b1);
      if (m_capturing) begin
        if (adc_valid === 1'b1 || st_on) begin
          e_en   = 1;
          e_addr = ADDR_W'(m_taken);
          e_data = st_on ? DATA_W'(m_taken) : adc_data;
          m_taken++;
          if (m_taken == DEPTH) begin
            m_capturing = 0;
            m_finished  = 1;
          end
        end
      end else if (capture_start === 1'b1 || (m_finished && capture_again === 1'b1)) begin
        m_capturing = 1;
        m_finished  = 0;
        m_taken     = 0;
      end
      e_busy = m_capturing;
      e_done = m_finished;
      e_cnt  = m_taken;
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("mem_wr_en", mem_wr_en, e_en);
      check("capture_busy", capture_busy, e_busy);
      check("capture_done", capture_done, e_done);
      check("wr_count", wr_count, e_cnt);
      if (e_en) begin
        check("mem_wr_addr", mem_wr_addr, e_addr);
        check("mem_wr_data", mem_wr_data, e_data);
      end
      if (mem_wr_en === 1'b1) begin
        n_wr++;
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     mem_wr_addr, mem_wr_data);
          end else begin
            check("sb_write", {mem_wr_addr, mem_wr_data}, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge, away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int r_cnt1, r_busy1, r_done1;

  // kind: 0 capture_start, 1 capture_again, 2 both.
  // vmode: 0 valid always 1, 1 valid on odd cycles, 2 valid always 0.
  // Extra requests are pulsed at n == req_at, req_at+4, req_at+8.
  task automatic run_capture(input int kind, input int vmode, input int req_at,
                             input int budget, output int lat);
    int n;
    capture_start = (kind != 1);
    capture_again = (kind != 0);
    adc_valid     = 1'b0;
    tick();
    capture_start = 1'b0;
    capture_again = 1'b0;
    n = 1;
    r_cnt1  = int'(wr_count);
    r_busy1 = int'(capture_busy);
    r_done1 = int'(capture_done);
    while (capture_done !== 1'b1 && n < budget) begin
      case (vmode)
        0:       adc_valid = 1'b1;
        1:       adc_valid = n[0];
        default: adc_valid = 1'b0;
      endcase
      adc_data      = DATA_W'(32'h2000 + n);
      capture_start = (req_at > 0) && (n == req_at || n == req_at + 8);
      capture_again = (req_at > 0) && (n == req_at + 4 || n == req_at + 8);
      tick();
      n++;
    end
    adc_valid     = 1'b0;
    capture_start = 1'b0;
    capture_again = 1'b0;
    lat = n;
  endtask

  // Expected writes when adc_valid is held high: sample n (1-based) carries 0x2000+n.
  task automatic push_adc_writes();
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({ADDR_W'(i), DATA_W'(32'h2000 + i + 1)});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, w0;
    bit seen5;
    rst = 1'b1; capture_start = 1'b0; capture_again = 1'b0;
    self_test_mode = 1'b0; adc_valid = 1'b0; adc_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_on = 1'b1;

    // Reset values
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_wr_addr", mem_wr_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    check("rst_busy", capture_busy, 0);
    check("rst_done", capture_done, 0);
    check("rst_wr_count", wr_count, 0);

    // Continuous valid: 16 back-to-back writes, done with the address-15 write
    sb_on = 1'b1; push_adc_writes(); w0 = n_wr;
    run_capture(0, 0, 0, 60, lat);
    check("t1_start_busy", r_busy1, 1);
    check("t1_done_latency", lat, 17);
    check("t1_last_addr", mem_wr_addr, 15);
    check("t1_last_data", mem_wr_data, 32'h2010);
    check("t1_wr_count", wr_count, 16);
    check("t1_busy_low", capture_busy, 0);
    check("t1_writes", n_wr - w0, 16);
    check("t1_sb_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // Alternating valid: writes two cycles apart, done 32 cycles after start
    w0 = n_wr;
    run_capture(0, 1, 0, 80, lat);
    check("t2_done_latency", lat, 32);
    check("t2_writes", n_wr - w0, 16);

    // Self-test with adc_valid low: counting pattern, or nothing without the feature
    self_test_mode = 1'b1; w0 = n_wr;
    sb_on = ST_EN;
    if (ST_EN) for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), DATA_W'(i)});
    run_capture(0, 2, 0, 40, lat);
    check("t3_latency", lat, ST_EN ? 17 : 40);
    check("t3_writes", n_wr - w0, ST_EN ? 16 : 0);
    check("t3_sb_drained", exp_q.size(), 0);
    sb_on = 1'b0;
    self_test_mode = 1'b0;
    run_capture(0, 0, 0, 60, lat);
    check("t3_recover_done", capture_done, 1);

    // Requests during CAPTURE are ignored; addresses stay monotonic
    sb_on = 1'b1; push_adc_writes(); w0 = n_wr;
    run_capture(0, 0, 3, 60, lat);
    check("t4_done_latency", lat, 17);
    check("t4_writes", n_wr - w0, 16);
    check("t4_sb_drained", exp_q.size(), 0);

    // capture_again from DONE restarts with wr_count back to 0
    push_adc_writes(); w0 = n_wr;
    run_capture(1, 0, 0, 60, lat);
    check("t4_again_cnt0", r_cnt1, 0);
    check("t4_again_busy", r_busy1, 1);
    check("t4_again_done0", r_done1, 0);
    check("t4_again_latency", lat, 17);
    check("t4_again_writes", n_wr - w0, 16);
    sb_on = 1'b0;

    // capture_again in IDLE does nothing
    rst = 1'b1; tick(); rst = 1'b0;
    w0 = n_wr;
    capture_again = 1'b1; adc_valid = 1'b1; tick();
    capture_again = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    adc_valid = 1'b0;
    check("t5_idle_busy", capture_busy, 0);
    check("t5_idle_writes", n_wr - w0, 0);
    run_capture(0, 0, 0, 60, lat);
    check("t5_first_latency", lat, 17);
    // Both requests in DONE: a single restart, one full capture
    w0 = n_wr;
    run_capture(2, 0, 0, 60, lat);
    check("t5_both_cnt0", r_cnt1, 0);
    check("t5_both_latency", lat, 17);
    check("t5_both_writes", n_wr - w0, 16);

    // Reset while the address-5 write is visible
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    seen5 = 1'b0;
    for (int i = 0; i < 20 && !seen5; i++) begin
      if (mem_wr_en === 1'b1 && mem_wr_addr == 5) seen5 = 1'b1;
      else begin
        adc_valid = 1'b1; adc_data = DATA_W'(32'h3000 + i); tick();
      end
    end
    check("t6_saw_addr5", seen5, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_wr_en", mem_wr_en, 0);
    check("t6_rst_addr", mem_wr_addr, 0);
    check("t6_rst_data", mem_wr_data, 0);
    check("t6_rst_busy", capture_busy, 0);
    check("t6_rst_count", wr_count, 0);
    w0 = n_wr;
    for (int i = 0; i < 6; i++) tick();
    adc_valid = 1'b0;
    check("t6_no_writes", n_wr - w0, 0);
    sb_on = 1'b1; push_adc_writes();
    run_capture(0, 0, 0, 60, lat);
    check("t6_restart_latency", lat, 17);
    check("t6_sb_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
